// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Digit-serial unsigned subtractor: computes a - b - bin over WIDTH bits,
// DIGIT bits per clock, carrying the borrow between steps in a register.
// A start/ready/done handshake sequences each operation. All outputs come
// straight from registers.
//
// Parameters:
//   WIDTH  operand/result width (must be a multiple of DIGIT)
//   DIGIT  bits processed per clock
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request a subtraction, sampled only while ready=1
//   a, b   minuend / subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   ready  idle, a start will be accepted
//   done   one-cycle pulse when diff/bout/zero have just been updated
//   diff   a - b - bin mod 2^WIDTH
//   bout   borrow-out, 1 iff a < b + bin
//   zero   1 iff diff == 0 (meaningful after the first done)

module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, nextState;

  // Working registers: operands shift right one digit per step while the
  // result fills in from the top, so the first (lowest) digit computed ends
  // up at the bottom after STEPS steps.
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic             brw;
  logic [WIDTH-1:0] wres;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dstep;
  logic [WIDTH-1:0] arShift;
  logic [WIDTH-1:0] brShift;
  logic [WIDTH-1:0] resNext;
  logic             accept;
  logic             lastStep;
  logic             unused_bits;

  // One digit of subtraction in DIGIT+1 bits; the MSB is the borrow out of
  // this digit.
  assign dstep = {1'b0, ar[DIGIT-1:0]} - {1'b0, br[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};

  // With a single step there is nothing to shift and the working result is
  // never read; otherwise the lowest working-result digit falls off the
  // bottom each step.
  generate
    if (STEPS == 1) begin : g_single
      assign arShift     = '0;
      assign brShift     = '0;
      assign resNext     = dstep[DIGIT-1:0];
      assign unused_bits = ^wres;
    end else begin : g_multi
      assign arShift     = {{DIGIT{1'b0}}, ar[WIDTH-1:DIGIT]};
      assign brShift     = {{DIGIT{1'b0}}, br[WIDTH-1:DIGIT]};
      assign resNext     = {dstep[DIGIT-1:0], wres[WIDTH-1:DIGIT]};
      assign unused_bits = ^wres[DIGIT-1:0];
    end
  endgenerate

  assign ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic and the accept/last-step strobes used by the datapath.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    lastStep  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(STEPS - 1)) begin
          lastStep  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: capture on accept, one digit per RUN edge, publish results
  // and pulse done on the last step. Results hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar   <= '0;
      br   <= '0;
      brw  <= 1'b0;
      wres <= '0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ar   <= a;
        br   <= b;
        brw  <= bin;
        wres <= '0;
        cnt  <= '0;
      end else if (state == RUN) begin
        ar   <= arShift;
        br   <= brShift;
        brw  <= dstep[DIGIT];
        wres <= resNext;
        cnt  <= cnt + CW'(1);
        if (lastStep) begin
          diff <= resNext;
          bout <= dstep[DIGIT];
          zero <= (resNext == '0);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, parametrised successor to the team's 1-bit full subtractor. It computes `a - b - bin` on WIDTH-bit unsigned operands, DIGIT bits per clock, and propagates the borrow between digit steps in a register. It sits in the datapath lab designs wherever a wide subtract is needed but a full-width combinational borrow chain is not wanted. A start/ready/done handshake sequences the operation.

## Interface
- WIDTH, 16, operand and result width in bits; WIDTH must be an exact multiple of DIGIT.
- DIGIT, 4, bits processed per clock; STEPS = WIDTH/DIGIT.
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a subtraction; sampled only when ready=1
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- ready  output  1  block idle, start will be accepted
- done  output  1  one-cycle pulse: result registers were just updated
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- zero  output  1  1 iff diff == 0

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE: ready=1.
  - start=1 at an edge: capture a, b, bin into working registers ar, br, brw.
  - Clear the step counter and working result; go to RUN.
- RUN: ready=0. At each edge, process the low DIGIT bits:
  - {nb, d} = {1'b0, ar[DIGIT-1:0]} - {1'b0, br[DIGIT-1:0]} - brw, with (DIGIT+1)-bit arithmetic; nb is the MSB.
  - brw <= nb.
  - ar and br shift right by DIGIT.
  - d shifts into the working result from the top, so the lowest digit ends at bits [DIGIT-1:0].
  - The step counter increments.
- Last RUN edge (counter = STEPS-1):
  - diff <= final working result; bout <= final nb; zero <= (final result == 0).
  - done <= 1; state goes to IDLE.
- done clears at the next edge unconditionally.
- diff, bout and zero change only on a done edge. They hold their value between operations and during a following operation.
- start while ready=0 is ignored. Changes on a, b and bin after acceptance have no effect.
- In the cycle where done=1, ready=1, so a back-to-back start is accepted.
- Counter width is clog2(STEPS) bits, minimum 1. The DIGIT=WIDTH case (STEPS=1) must work: one RUN edge.
- Reset mid-operation: all state is cleared and the block returns to IDLE. No done pulse is produced and the in-flight operation is discarded.

## Timing
- Reset values: ready=1, done=0, diff=0, bout=0, zero=0.
  - zero resets to 0 even though diff=0; it is meaningful only after the first done.
- Accept edge E0, when IDLE and start=1. Digit edges are E1..E_STEPS.
- Results and done are visible after edge E_STEPS, so latency is STEPS cycles from the accept edge.
- ready is low after E0 through E_STEPS; it is high again in the done cycle.
- Throughput: one result per STEPS cycles with back-to-back starts.
- All outputs are registered. There is no combinational path from the inputs to any output.

## Test plan
- Reset: hold rst_n=0 with start=1 -> ready=1, done=0, diff=0x0000, bout=0, zero=0. Release -> still IDLE until start is sampled.
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0234, bin=0 -> done exactly 4 cycles after the accept edge, diff=0x1000, bout=0, zero=0. done lasts one cycle and diff holds afterwards.
- Borrow across all digits: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0.
- Zero with borrow-in: a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0, zero=1.
- Handshake:
  - Pulse start with a=0xFFFF, b=0x0001 mid-RUN -> ignored; the current result is unchanged.
  - Assert start in the done cycle with a=0x0005, b=0x0007 -> accepted. After 4 cycles, diff=0xFFFE, bout=1.
- Reset mid-run plus parameter sweep:
  - Drop rst_n after 2 digit edges -> no done; outputs return to reset values.
  - Repeat the 0x05-0x07 case with WIDTH=8, DIGIT=1 -> done after 8 cycles, diff=0xFE, bout=1.
  - Repeat with WIDTH=8, DIGIT=8 -> done after 1 cycle, diff=0xFE, bout=1.
